uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
Frame-level controller for the UART receiver. It owns the edge and bit counters and drives the oversampling data sampler, which takes a majority vote over three mid-bit samples. It sequences the start, data, optional parity and stop phases, shifts sampled bits into the parallel word, and checks parity, stop and start-glitch conditions. It sits between the RX pin synchroniser and the RX output register / async FIFO feeding the system controller.

Parameters:
DATA_WIDTH, 8, payload bits per frame (LSB first)
PRESC_W, 5, width of Prescale and edge_cnt

Ports:
CLK  input  1  receiver oversampling clock
RST  input  1  reset, synchronous, active-low
RX_IN  input  1  serial line, already synchronised, idle high
Prescale  input  PRESC_W  oversampling ratio; legal values 8 and 16; quasi-static, sampled only in IDLE
PAR_EN  input  1  1 = frame carries a parity bit
PAR_TYP  input  1  0 = even, 1 = odd
sampled_bit  input  1  majority-voted bit from the sampler
data_samp_en  output  1  sampler enable
edge_cnt  output  PRESC_W  oversampling edge index within the current bit
P_DATA  output  DATA_WIDTH  received word
data_valid  output  1  one-cycle pulse, word good
par_err  output  1  parity error flag
stp_err  output  1  stop error flag

Behaviour:
- Reset: all logic is synchronous to the CLK rising edge; RST=0 is sampled on CLK and takes precedence over all other logic.
- Reset values: state=IDLE, edge_cnt=0, bit_cnt=0, P_DATA=0, data_valid=0, par_err=0, stp_err=0, data_samp_en=0.
- States: IDLE, START, DATA, PARITY, STOP.
- data_samp_en is 1 in every state except IDLE.
- Prescale is latched into an internal register on the IDLE→START transition. A change mid-frame has no effect.
- edge_cnt:
  - Held at 0 in IDLE.
  - Otherwise increments by 1 per CLK.
  - At latched Prescale-1 it wraps to 0, and that wrap cycle is the bit boundary.
- Bit evaluation:
  - sampled_bit is considered stable from edge Prescale/2+2.
  - The controller evaluates it only on the boundary cycle (edge_cnt==Prescale-1).
- IDLE: RX_IN==0 → START. On this transition par_err and stp_err clear to 0.
- START boundary:
  - sampled_bit==1 → glitch: go to IDLE, raise no flags, no data_valid.
  - sampled_bit==0 → DATA, bit_cnt=0.
- DATA boundary:
  - P_DATA <= {sampled_bit, P_DATA[DATA_WIDTH-1:1]}; bit_cnt += 1.
  - After DATA_WIDTH bits, go to PARITY if PAR_EN, else STOP.
- PARITY boundary:
  - expected = ^P_DATA XOR PAR_TYP.
  - par_err <= (sampled_bit != expected).
  - Always continue to STOP.
- STOP boundary:
  - stp_err <= ~sampled_bit.
  - data_valid pulses 1 on the next cycle iff sampled_bit==1 and par_err==0.
  - Next state is START if RX_IN==0 on this cycle (back-to-back frame), else IDLE.
- Flags: par_err and stp_err are level flags held until the next frame start. P_DATA holds its value until the next DATA shift.
- data_valid: exactly one CLK wide. Never asserted for a glitched or errored frame.
- Partial shifts: P_DATA contents during DATA are partial and must not be consumed; only data_valid qualifies the word.
- PAR_EN and PAR_TYP are sampled at the point of use (end of the last DATA bit, and the PARITY boundary).
- Reset mid-frame: return to IDLE at the reset values on the next CLK; no data_valid.
- Line held low (break): the frame completes with stp_err=1, then re-enters START immediately. This repeats per frame time; no lock-up.

Decomposition:
- Shared uart_pkg: state encoding constants (IDLE..STOP), default DATA_WIDTH, legal Prescale constants 8 and 16.
- One natural sub-module: uart_rx_edge_bit_counter (edge_cnt/bit_cnt with enable, wrap and boundary strobe). The FSM, shifter and checks stay in uart_rx_ctrl.

Test Plan:
- Prescale=8, PAR_EN=0, byte 0xA5 LSB first, stop=1 → P_DATA=0xA5, data_valid one cycle, 8 clocks after the stop boundary region; flags 0.
- Prescale=16, PAR_EN=1, PAR_TYP=0, 0x3C with parity bit 0 → data_valid, par_err=0; same frame with parity bit 1 → par_err=1, no data_valid.
- Prescale=8, PAR_TYP=1, 0x01 with parity bit 0 → par_err=0, data_valid=1.
- RX_IN low for 3 clocks then high (start glitch) → return to IDLE after 8 clocks; no data_valid, flags 0, P_DATA unchanged.
- Stop bit sent as 0 with byte 0x55 → stp_err=1, no data_valid; next frame 0xF0 sent back-to-back → stp_err cleared at start, P_DATA=0xF0, data_valid.
- RST driven low during DATA bit 4 of Prescale=16 → next CLK: state IDLE, edge_cnt=0, data_samp_en=0; no data_valid afterwards until a full new frame.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and constants for the UART receive path
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int PRESC_8        = 8;
  localparam int PRESC_16       = 16;

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// rtl/uart_rx_edge_bit_counter.sv - oversampling edge counter with bit boundary strobe and bit counter
module uart_rx_edge_bit_counter #(
  parameter int PRESC_W = 5,
  parameter int BIT_W   = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic [PRESC_W-1:0] presc_i,
  input  logic               bit_clr_i,
  input  logic               bit_inc_i,
  output logic [PRESC_W-1:0] edge_cnt_o,
  output logic [BIT_W-1:0]   bit_cnt_o,
  output logic               boundary_o
);

  logic [PRESC_W-1:0] edge_q, edge_d;
  logic [BIT_W-1:0]   bit_q, bit_d;

  // The wrap cycle of the edge counter is the only cycle a bit is evaluated.
  assign boundary_o = en_i && (edge_q == (presc_i - PRESC_W'(1)));

  always_comb begin
    edge_d = '0;
    if (en_i && !boundary_o) begin
      edge_d = edge_q + PRESC_W'(1);
    end
    bit_d = bit_q;
    if (bit_clr_i) begin
      bit_d = '0;
    end else if (boundary_o && bit_inc_i) begin
      bit_d = bit_q + BIT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      edge_q <= '0;
      bit_q  <= '0;
    end else begin
      edge_q <= edge_d;
      bit_q  <= bit_d;
    end
  end

  assign edge_cnt_o = edge_q;
  assign bit_cnt_o  = bit_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive frame controller: start/data/parity/stop sequencing and checks
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PRESC_W    = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESC_W-1:0]    Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  sampled_bit,
  output logic                  data_samp_en,
  output logic [PRESC_W-1:0]    edge_cnt,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int BIT_W = $clog2(DATA_WIDTH + 1);

  rx_state_e             state_q;
  logic [PRESC_W-1:0]    presc_q;
  logic [DATA_WIDTH-1:0] p_data_q;
  logic                  data_samp_en_q;
  logic                  data_valid_q;
  logic                  par_err_q;
  logic                  stp_err_q;

  logic                  cnt_en;
  logic                  boundary;
  logic                  bit_clr;
  logic                  last_bit;
  logic [BIT_W-1:0]      bit_cnt;

  assign cnt_en   = (state_q != ST_IDLE);
  assign bit_clr  = (state_q == ST_START) && boundary;
  assign last_bit = (bit_cnt == BIT_W'(DATA_WIDTH - 1));

  uart_rx_edge_bit_counter #(
    .PRESC_W (PRESC_W),
    .BIT_W   (BIT_W)
  ) u_counter (
    .clk_i      (CLK),
    .rst_ni     (RST),
    .en_i       (cnt_en),
    .presc_i    (presc_q),
    .bit_clr_i  (bit_clr),
    .bit_inc_i  (state_q == ST_DATA),
    .edge_cnt_o (edge_cnt),
    .bit_cnt_o  (bit_cnt),
    .boundary_o (boundary)
  );

  // Flags are also cleared when a start bit is confirmed, so a back-to-back
  // frame reports the previous stop error during its start bit only.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q        <= ST_IDLE;
      presc_q        <= PRESC_W'(PRESC_8);
      p_data_q       <= '0;
      data_samp_en_q <= 1'b0;
      data_valid_q   <= 1'b0;
      par_err_q      <= 1'b0;
      stp_err_q      <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!RX_IN) begin
            state_q        <= ST_START;
            presc_q        <= Prescale;
            par_err_q      <= 1'b0;
            stp_err_q      <= 1'b0;
            data_samp_en_q <= 1'b1;
          end
        end
        ST_START: begin
          if (boundary) begin
            if (sampled_bit) begin
              state_q        <= ST_IDLE;
              data_samp_en_q <= 1'b0;
            end else begin
              state_q   <= ST_DATA;
              par_err_q <= 1'b0;
              stp_err_q <= 1'b0;
            end
          end
        end
        ST_DATA: begin
          if (boundary) begin
            p_data_q <= {sampled_bit, p_data_q[DATA_WIDTH-1:1]};
            if (last_bit) begin
              state_q <= PAR_EN ? ST_PARITY : ST_STOP;
            end
          end
        end
        ST_PARITY: begin
          if (boundary) begin
            par_err_q <= (sampled_bit != ((^p_data_q) ^ PAR_TYP));
            state_q   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (boundary) begin
            stp_err_q    <= ~sampled_bit;
            data_valid_q <= sampled_bit & ~par_err_q;
            if (RX_IN) begin
              state_q        <= ST_IDLE;
              data_samp_en_q <= 1'b0;
            end else begin
              state_q <= ST_START;
            end
          end
        end
        default: begin
          state_q        <= ST_IDLE;
          data_samp_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign data_samp_en = data_samp_en_q;
  assign P_DATA       = p_data_q;
  assign data_valid   = data_valid_q;
  assign par_err      = par_err_q;
  assign stp_err      = stp_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - self-checking bench for uart_rx_ctrl with a frame-level reference model
module tb_uart_rx_ctrl;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          RST = 1'b0;
  logic          RX_IN = 1'b1;
  logic [4:0]    Prescale = 5'd8;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic          sampled_bit = 1'b1;
  logic          data_samp_en;
  logic [4:0]    edge_cnt;
  logic [DW-1:0] P_DATA;
  logic          data_valid;
  logic          par_err;
  logic          stp_err;

  uart_rx_ctrl dut (
    .CLK          (clk),
    .RST          (RST),
    .RX_IN        (RX_IN),
    .Prescale     (Prescale),
    .PAR_EN       (PAR_EN),
    .PAR_TYP      (PAR_TYP),
    .sampled_bit  (sampled_bit),
    .data_samp_en (data_samp_en),
    .edge_cnt     (edge_cnt),
    .P_DATA       (P_DATA),
    .data_valid   (data_valid),
    .par_err      (par_err),
    .stp_err      (stp_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;
  int dv_cnt = 0;
  logic [DW-1:0] dv_word = '0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Sampler: majority of three mid-bit line samples, as the real sampler does.
  int tb_p = 8;
  logic s0 = 1'b1, s1 = 1'b1;
  always @(posedge clk) begin
    if (data_samp_en) begin
      if (edge_cnt == 5'(tb_p / 2 - 1)) s0 <= RX_IN;
      else if (edge_cnt == 5'(tb_p / 2)) s1 <= RX_IN;
      else if (edge_cnt == 5'(tb_p / 2 + 1))
        sampled_bit <= (s0 & s1) | (s0 & RX_IN) | (s1 & RX_IN);
    end
  end

  // Reference model: frame timeline from the line history, by cycle arithmetic.
  logic          line_h [0:65535];
  int            cyc = 0;
  bit            m_busy = 0;
  int            m_t0 = 0;
  int            m_p = 8;
  bit            m_has_par = 0;
  logic [DW-1:0] m_pdata = '0;
  bit            m_par = 0, m_stp = 0, m_dv = 0;
  int            m_edge = 0;
  int            rel, b;
  logic          v;

  function automatic logic maj(input int base);
    logic a, c, d;
    a = line_h[base & 16'hFFFF];
    c = line_h[(base + 1) & 16'hFFFF];
    d = line_h[(base + 2) & 16'hFFFF];
    return (a & c) | (a & d) | (c & d);
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      line_h[cyc & 16'hFFFF] = RX_IN;
      m_dv = 0;
      if (!RST) begin
        m_busy = 0; m_pdata = '0; m_par = 0; m_stp = 0;
      end else if (!m_busy) begin
        if (!RX_IN) begin
          m_busy = 1; m_t0 = cyc; m_p = int'(Prescale); m_par = 0; m_stp = 0;
        end
      end else begin
        rel = cyc - m_t0;
        if (rel % m_p == 0) begin
          b = rel / m_p - 1;
          v = maj(m_t0 + b * m_p + m_p / 2);
          if (b == 0) begin
            if (v) m_busy = 0;
            else begin m_par = 0; m_stp = 0; end
          end else if (b <= DW) begin
            m_pdata = {v, m_pdata[DW-1:1]};
            if (b == DW) m_has_par = PAR_EN;
          end else if (m_has_par && b == DW + 1) begin
            m_par = (v != ((^m_pdata) ^ PAR_TYP));
          end else begin
            m_stp = !v;
            m_dv = v && !m_par;
            if (!RX_IN) m_t0 = cyc;
            else m_busy = 0;
          end
        end
      end
      m_edge = m_busy ? (cyc - m_t0) % m_p : 0;
      cyc++;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        chk("samp_en", int'(data_samp_en), int'(m_busy));
        chk("edge_cnt", int'(edge_cnt), m_edge);
        chk("p_data", int'(P_DATA), int'(m_pdata));
        chk("data_valid", int'(data_valid), int'(m_dv));
        chk("par_err", int'(par_err), int'(m_par));
        chk("stp_err", int'(stp_err), int'(m_stp));
        if (data_valid) begin
          dv_cnt++;
          dv_word = P_DATA;
        end
      end
    end
  end

  task automatic drive_bit(input logic val, input int n);
    RX_IN = val;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input int p, input logic [DW-1:0] d, input bit pe, input bit pt,
                            input bit pbit_ok, input logic stop, input int gap, input int pre,
                            input bit wiggle);
    logic pb;
    tb_p = p; Prescale = 5'(p); PAR_EN = pe; PAR_TYP = pt;
    drive_bit(1'b0, p - pre);
    if (wiggle) Prescale = (p == 8) ? 5'd16 : 5'd8;
    for (int i = 0; i < DW; i++) drive_bit(d[i], p);
    pb = (^d) ^ pt;
    if (pe) drive_bit(pbit_ok ? pb : ~pb, p);
    drive_bit(stop, p);
    Prescale = 5'(p);
    drive_bit(1'b1, gap);
  endtask

  task automatic glitch(input int p, input int len);
    tb_p = p; Prescale = 5'(p);
    drive_bit(1'b0, len);
    drive_bit(1'b1, p + 2);
  endtask

  int base;
  int p, gap, prev_gap;

  initial begin
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    chk("rst_samp_en", int'(data_samp_en), 0);
    chk("rst_edge", int'(edge_cnt), 0);
    chk("rst_pdata", int'(P_DATA), 0);
    chk("rst_flags", int'({data_valid, par_err, stp_err}), 0);
    RST = 1'b1;
    drive_bit(1'b1, 4);

    base = dv_cnt;
    send_frame(8, 8'hA5, 0, 0, 1, 1'b1, 4, 0, 0);
    chk("a5_dv_count", dv_cnt - base, 1);
    chk("a5_word", int'(dv_word), 8'hA5);
    chk("a5_flags", int'({par_err, stp_err}), 0);

    base = dv_cnt;
    send_frame(16, 8'h3C, 1, 0, 1, 1'b1, 4, 0, 0);
    chk("3c_even_ok_dv", dv_cnt - base, 1);
    chk("3c_even_ok_par", int'(par_err), 0);
    base = dv_cnt;
    send_frame(16, 8'h3C, 1, 0, 0, 1'b1, 4, 0, 0);
    chk("3c_even_bad_dv", dv_cnt - base, 0);
    chk("3c_even_bad_par", int'(par_err), 1);

    base = dv_cnt;
    send_frame(8, 8'h01, 1, 1, 1, 1'b1, 4, 0, 0);
    chk("01_odd_dv", dv_cnt - base, 1);
    chk("01_odd_par", int'(par_err), 0);

    base = dv_cnt;
    glitch(8, 3);
    chk("glitch_dv", dv_cnt - base, 0);
    chk("glitch_flags", int'({par_err, stp_err}), 0);
    chk("glitch_pdata", int'(P_DATA), 8'h01);
    chk("glitch_idle", int'(data_samp_en), 0);

    base = dv_cnt;
    send_frame(8, 8'h55, 0, 0, 1, 1'b0, 0, 0, 0);
    RX_IN = 1'b0;
    @(negedge clk);
    chk("b2b_stp_set", int'(stp_err), 1);
    send_frame(8, 8'hF0, 0, 0, 1, 1'b1, 4, 1, 0);
    chk("b2b_dv_count", dv_cnt - base, 1);
    chk("b2b_word", int'(dv_word), 8'hF0);
    chk("b2b_stp_clr", int'(stp_err), 0);

    base = dv_cnt;
    for (int i = 0; i < 3; i++) send_frame(8, 8'h00, 0, 0, 1, 1'b0, 0, 0, 0);
    drive_bit(1'b1, 6);
    chk("break_dv", dv_cnt - base, 0);
    chk("break_stp", int'(stp_err), 1);
    send_frame(8, 8'h3A, 0, 0, 1, 1'b1, 4, 0, 1);
    chk("post_break_dv", dv_cnt - base, 1);
    chk("post_break_word", int'(dv_word), 8'h3A);

    base = dv_cnt;
    tb_p = 16; Prescale = 5'd16; PAR_EN = 1'b0;
    drive_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 16);
    drive_bit(1'b0, 8);
    RST = 1'b0; RX_IN = 1'b1;
    @(negedge clk);
    chk("midrst_samp_en", int'(data_samp_en), 0);
    chk("midrst_edge", int'(edge_cnt), 0);
    chk("midrst_pdata", int'(P_DATA), 0);
    RST = 1'b1;
    drive_bit(1'b1, 40);
    chk("midrst_no_dv", dv_cnt - base, 0);

    prev_gap = 4;
    p = 8;
    for (int n = 0; n < 120; n++) begin
      if (prev_gap > 0) p = ($urandom_range(0, 1) == 0) ? 8 : 16;
      if (prev_gap > 0 && $urandom_range(0, 7) == 0) begin
        glitch(p, $urandom_range(1, p / 2 - 1));
        prev_gap = 1;
      end else begin
        gap = $urandom_range(0, 3);
        send_frame(p, 8'($urandom), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                   $urandom_range(0, 4) != 0, logic'($urandom_range(0, 6) != 0), gap, 0,
                   $urandom_range(0, 5) == 0);
        prev_gap = gap;
      end
    end
    drive_bit(1'b1, 30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
